// File: rtl/bus_mux_reg.sv
// Registered priority bus multiplexer with collision detection and a saturating collision counter.
// Optional macro BUS_CSIGN_EXT_EN: sign-extend the top source (C immediate) from IMM_W bits before selection.
module bus_mux_reg #(
    parameter int NUM_SRC = 24,
    parameter int WIDTH   = 32,
    parameter int IMM_W   = 19,
    parameter int CNT_W   = 8
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic [NUM_SRC*WIDTH-1:0] src_data,
    input  logic [NUM_SRC-1:0]       src_oe,
    input  logic                     err_clr,
    output logic [WIDTH-1:0]         bus_out,
    output logic [$clog2(NUM_SRC)-1:0] bus_src,
    output logic                     bus_driven,
    output logic                     collision,
    output logic                     collision_sticky,
    output logic [CNT_W-1:0]         collision_cnt
);

    localparam int SEL_W = $clog2(NUM_SRC);
    localparam int IMM_BASE = (NUM_SRC - 1) * WIDTH;

    logic [WIDTH-1:0] src_word [NUM_SRC];
    logic [WIDTH-1:0] win_data;
    logic [SEL_W-1:0] win_idx;
    logic             any_oe;
    logic             multi_oe;

    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            src_word[i] = src_data[i*WIDTH +: WIDTH];
        end
`ifdef BUS_CSIGN_EXT_EN
        src_word[NUM_SRC-1] = {{(WIDTH-IMM_W){src_data[IMM_BASE+IMM_W-1]}},
                               src_data[IMM_BASE +: IMM_W]};
`else
        src_word[NUM_SRC-1] = src_data[IMM_BASE +: WIDTH];
`endif
    end

    // NOTE: defaults assigned before the loop so no path leaves win_* unassigned (no latch).
    always_comb begin
        win_idx  = '0;
        win_data = src_word[0];
        // NOTE: blocking assignments here; a later (higher) enabled index overwrites earlier ones.
        for (int i = 0; i < NUM_SRC; i++) begin
            if (src_oe[i]) begin
                win_idx  = SEL_W'(i);
                win_data = src_word[i];
            end
        end
    end

    // Clearing the lowest set bit leaves a nonzero value only when two or more bits are set.
    assign any_oe   = |src_oe;
    assign multi_oe = |(src_oe & (src_oe - NUM_SRC'(1)));

    // NOTE: non-blocking assignments for all state so every flop sees pre-edge values.
    always_ff @(posedge clk) begin
        if (clr) begin
            bus_out          <= '0;
            bus_src          <= '0;
            bus_driven       <= 1'b0;
            collision        <= 1'b0;
            collision_sticky <= 1'b0;
            collision_cnt    <= '0;
        end else begin
            if (any_oe) begin
                bus_out <= win_data;
                bus_src <= win_idx;
            end
            bus_driven <= any_oe;
            collision  <= multi_oe;

            // err_clr only overrides the debug counters; the bus path above is unaffected.
            if (err_clr) begin
                collision_sticky <= 1'b0;
                collision_cnt    <= '0;
            end else if (multi_oe) begin
                collision_sticky <= 1'b1;
                if (collision_cnt != {CNT_W{1'b1}}) begin
                    collision_cnt <= collision_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_bus_mux_reg.sv
// Directed self-checking bench for bus_mux_reg at default parameters.
// Expectations for the top source follow BUS_CSIGN_EXT_EN when it is defined for the build.
module tb_bus_mux_reg;

    localparam int NUM_SRC = 24;
    localparam int WIDTH   = 32;
    localparam int CNT_W   = 8;

    logic                     clk = 1'b0;
    logic                     clr;
    logic [NUM_SRC*WIDTH-1:0] src_data;
    logic [NUM_SRC-1:0]       src_oe;
    logic                     err_clr;
    logic [WIDTH-1:0]         bus_out;
    logic [4:0]               bus_src;
    logic                     bus_driven;
    logic                     collision;
    logic                     collision_sticky;
    logic [CNT_W-1:0]         collision_cnt;

    int total = 0;
    int bad   = 0;

    bus_mux_reg dut (
        .clk              (clk),
        .clr              (clr),
        .src_data         (src_data),
        .src_oe           (src_oe),
        .err_clr          (err_clr),
        .bus_out          (bus_out),
        .bus_src          (bus_src),
        .bus_driven       (bus_driven),
        .collision        (collision),
        .collision_sticky (collision_sticky),
        .collision_cnt    (collision_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic set_src(input int idx, input logic [WIDTH-1:0] val);
        src_data[idx*WIDTH +: WIDTH] = val;
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".bus_out"}, bus_out, 32'h0);
        check({tag, ".bus_src"}, 32'(bus_src), 32'd0);
        check({tag, ".bus_driven"}, 32'(bus_driven), 32'd0);
        check({tag, ".collision"}, 32'(collision), 32'd0);
        check({tag, ".sticky"}, 32'(collision_sticky), 32'd0);
        check({tag, ".cnt"}, 32'(collision_cnt), 32'd0);
    endtask

    initial begin
        src_data = '0;
        for (int i = 0; i < NUM_SRC; i++) set_src(i, 32'h1000_0000 + 32'(i));
        err_clr = 1'b0;

        // Reset with arbitrary enables active.
        clr    = 1'b1;
        src_oe = 24'h0F_00F0;
        #1;
        step();
        check_all_zero("reset");

        // Single source R5.
        clr = 1'b0;
        set_src(5, 32'h1234_5678);
        src_oe = 24'(1) << 5;
        step();
        check("t1.bus_out", bus_out, 32'h1234_5678);
        check("t1.bus_src", 32'(bus_src), 32'd5);
        check("t1.bus_driven", 32'(bus_driven), 32'd1);
        check("t1.collision", 32'(collision), 32'd0);

        // Hold for three edges while R5 changes.
        src_oe = '0;
        for (int k = 0; k < 3; k++) begin
            set_src(5, 32'hCAFE_0000 + 32'(k));
            step();
            check("t2.bus_out", bus_out, 32'h1234_5678);
            check("t2.bus_src", 32'(bus_src), 32'd5);
            check("t2.bus_driven", 32'(bus_driven), 32'd0);
            check("t2.collision", 32'(collision), 32'd0);
        end

        // Two enables: R2 and MDR(21); the higher index wins.
        set_src(2, 32'hAAAA_AAAA);
        set_src(21, 32'h0000_00FF);
        src_oe = (24'(1) << 2) | (24'(1) << 21);
        step();
        check("t3.bus_out", bus_out, 32'h0000_00FF);
        check("t3.bus_src", 32'(bus_src), 32'd21);
        check("t3.bus_driven", 32'(bus_driven), 32'd1);
        check("t3.collision", 32'(collision), 32'd1);
        check("t3.sticky", 32'(collision_sticky), 32'd1);
        check("t3.cnt", 32'(collision_cnt), 32'd1);

        // 300 collision cycles in total; counter must saturate at 255.
        repeat (299) step();
        check("t4.cnt_sat", 32'(collision_cnt), 32'd255);
        check("t4.sticky", 32'(collision_sticky), 32'd1);

        // err_clr during a collision clears the counters but not the collision flag.
        err_clr = 1'b1;
        set_src(21, 32'h0000_0077);
        step();
        check("t4.clr_cnt", 32'(collision_cnt), 32'd0);
        check("t4.clr_sticky", 32'(collision_sticky), 32'd0);
        check("t4.clr_collision", 32'(collision), 32'd1);
        check("t4.clr_bus_out", bus_out, 32'h0000_0077);
        err_clr = 1'b0;
        step();
        check("t4.recount", 32'(collision_cnt), 32'd1);
        check("t4.resticky", 32'(collision_sticky), 32'd1);

        // Three enables: highest index 22 wins.
        set_src(0, 32'h0000_0001);
        set_src(7, 32'h0000_0007);
        set_src(22, 32'h2222_2222);
        src_oe = 24'(1) | (24'(1) << 7) | (24'(1) << 22);
        step();
        check("t4b.bus_out", bus_out, 32'h2222_2222);
        check("t4b.bus_src", 32'(bus_src), 32'd22);
        check("t4b.cnt", 32'(collision_cnt), 32'd2);

        // C immediate source (index 23), bit IMM_W-1 set.
        set_src(23, 32'h0004_0000);
        src_oe = 24'(1) << 23;
        step();
`ifdef BUS_CSIGN_EXT_EN
        check("t5.bus_out", bus_out, 32'hFFFC_0000);
`else
        check("t5.bus_out", bus_out, 32'h0004_0000);
`endif
        check("t5.bus_src", 32'(bus_src), 32'd23);
        check("t5.collision", 32'(collision), 32'd0);
        check("t5.sticky_hold", 32'(collision_sticky), 32'd1);
        check("t5.cnt_hold", 32'(collision_cnt), 32'd2);

        // Single enable at the lowest index.
        src_oe = 24'(1);
        step();
        check("t5b.bus_out", bus_out, 32'h0000_0001);
        check("t5b.bus_src", 32'(bus_src), 32'd0);

        // clr together with a valid enable while sticky is set: nothing captured.
        set_src(4, 32'hDEAD_BEEF);
        src_oe = 24'(1) << 4;
        clr = 1'b1;
        step();
        check_all_zero("t6");
        clr = 1'b0;
        src_oe = '0;
        step();
        check("t6.hold_bus_out", bus_out, 32'h0);
        check("t6.hold_driven", 32'(bus_driven), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
